// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register of the 5-stage MIPS core: passes, bubbles or holds the
// execute-stage results and carries the two-step MADD/MSUB state back to execute.
module ex_mem_reg #(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [5:0]        stall,
   input  logic              ex_en_wd,
   input  logic [AW-1:0]     ex_desReg_addr,
   input  logic [DW-1:0]     ex_result,
   input  logic              ex_en_hilo,
   input  logic [DW-1:0]     ex_hi,
   input  logic [DW-1:0]     ex_lo,
   input  logic [2*DW-1:0]   hilo_tmp_i,
   input  logic [1:0]        count_i,
   output logic              mem_en_wd,
   output logic [AW-1:0]     mem_desReg_addr,
   output logic [DW-1:0]     mem_result,
   output logic              mem_en_hilo,
   output logic [DW-1:0]     mem_hi,
   output logic [DW-1:0]     mem_lo,
   output logic [2*DW-1:0]   hilo_tmp_o,
   output logic [1:0]        count_o
);

   localparam logic [1:0] MODE_PASS   = 2'd0;
   localparam logic [1:0] MODE_BUBBLE = 2'd1;
   localparam logic [1:0] MODE_HOLD   = 2'd2;

   logic [1:0] mode;

   logic              en_wd_q,   en_wd_d;
   logic [AW-1:0]     addr_q,    addr_d;
   logic [DW-1:0]     result_q,  result_d;
   logic              en_hilo_q, en_hilo_d;
   logic [DW-1:0]     hi_q,      hi_d;
   logic [DW-1:0]     lo_q,      lo_d;
   logic [2*DW-1:0]   tmp_q,     tmp_d;
   logic [1:0]        count_q,   count_d;

   // Only the execute and memory stall bits matter to this stage.
   logic unused_stall;
   assign unused_stall = ^{stall[5], stall[2:0]};

   // A memory-stage stall wins over everything, even a lone stall[4] the controller never emits.
   always_comb begin
      if (stall[4])      mode = MODE_HOLD;
      else if (stall[3]) mode = MODE_BUBBLE;
      else               mode = MODE_PASS;
   end

   always_comb begin
      // NOTE: every _d defaults to its _q first, so HOLD needs no branch and no latch is inferred.
      en_wd_d   = en_wd_q;
      addr_d    = addr_q;
      result_d  = result_q;
      en_hilo_d = en_hilo_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      tmp_d     = tmp_q;
      count_d   = count_q;
      case (mode)
         MODE_PASS: begin
            en_wd_d   = ex_en_wd;
            addr_d    = ex_desReg_addr;
            result_d  = ex_result;
            en_hilo_d = ex_en_hilo;
            hi_d      = ex_hi;
            lo_d      = ex_lo;
            tmp_d     = '0;
            count_d   = '0;
         end
         MODE_BUBBLE: begin
            en_wd_d   = 1'b0;
            addr_d    = '0;
            result_d  = '0;
            en_hilo_d = 1'b0;
            hi_d      = '0;
            lo_d      = '0;
            tmp_d     = hilo_tmp_i;
            count_d   = count_i;
         end
         default: ;
      endcase
   end

   // NOTE: state updates use non-blocking assignments so all registers sample the same pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_wd_q   <= 1'b0;
         addr_q    <= '0;
         result_q  <= '0;
         en_hilo_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         tmp_q     <= '0;
         count_q   <= '0;
      end else begin
         en_wd_q   <= en_wd_d;
         addr_q    <= addr_d;
         result_q  <= result_d;
         en_hilo_q <= en_hilo_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         tmp_q     <= tmp_d;
         count_q   <= count_d;
      end
   end

   assign mem_en_wd       = en_wd_q;
   assign mem_desReg_addr = addr_q;
   assign mem_result      = result_q;
   assign mem_en_hilo     = en_hilo_q;
   assign mem_hi          = hi_q;
   assign mem_lo          = lo_q;
   assign hilo_tmp_o      = tmp_q;
   assign count_o         = count_q;

endmodule
